// File: rtl/div_restoring_if.sv
// Start/done bus for the iterative restoring divider.
// The master drives the request side and the slave (divider) drives results and status.
interface div_restoring_if #(
  parameter int W = 8
) ();
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  // start is sampled only while the divider is idle or done; a sample of
  // start=1 there accepts dividend/divisor on that edge. done is a one-cycle
  // pulse, and quotient/remainder/div_by_zero hold until the next acceptance.
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, dbg_state
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, dbg_state
  );
endinterface

// File: rtl/div_restoring.sv
// Iterative restoring divider: one trial subtraction per clock, computed as
// P + ~D + 1 through a generate/propagate carry-lookahead network.
module div_restoring #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  div_restoring_if.slave bus
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W:0]    r_q, r_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [W:0]    s;
  logic [W:0]    sub_b;
  logic [W:0]    g;
  logic [W:0]    p;
  logic [W+1:0]  c;
  logic [W:0]    t;
  logic          borrow;

  assign s     = {r_q[W-1:0], q_q[W-1]};
  assign sub_b = ~{1'b0, d_q};
  assign g     = s & sub_b;
  assign p     = s ^ sub_b;

  // Each carry is the flattened lookahead sum of products, with carry-in 1.
  always_comb begin
    logic c_acc;
    logic p_run;
    c[0] = 1'b1;
    for (int i = 0; i <= W; i++) begin
      c_acc = g[i];
      p_run = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c_acc = c_acc | (p_run & g[j]);
        p_run = p_run & p[j];
      end
      c[i+1] = c_acc | p_run;
    end
  end

  assign t      = p ^ c[W:0];
  assign borrow = ~c[W+1];

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          d_d     = bus.divisor;
          q_d     = bus.dividend;
          r_d     = '0;
          cnt_d   = '0;
          dbz_d   = 1'b0;
          state_d = RUN;
          // A zero divisor finishes immediately with saturated quotient.
          if (bus.divisor == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
          end
        end
      end
      RUN: begin
        if (borrow) begin
          r_d = s;
          q_d = {q_q[W-2:0], 1'b0};
        end else begin
          r_d = t;
          q_d = {q_q[W-2:0], 1'b1};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          quot_d  = q_d;
          rem_d   = r_d[W-1:0];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_div_restoring.sv
// Directed and randomized checks of div_restoring against an arithmetic
// reference model (plain / and %), including latency and handshake behaviour.
module tb_div_restoring;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  div_restoring_if #(.W(W)) bus ();

  div_restoring #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  // Called just after the accepting edge; returns at the cycle where done=1.
  task automatic wait_done(output int busy_cycles, output bit seen);
    busy_cycles = 0;
    seen        = 1'b0;
    for (int i = 0; i < 4 * W && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else begin
        if (bus.busy) busy_cycles++;
        tick();
      end
    end
  endtask

  // Scoreboard: expected results are pushed at launch and popped at done.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r[$];
  logic         exp_z[$];

  task automatic push_model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) begin
      exp_q.push_back({W{1'b1}});
      exp_r.push_back(a);
      exp_z.push_back(1'b1);
    end else begin
      exp_q.push_back(a / b);
      exp_r.push_back(a % b);
      exp_z.push_back(1'b0);
    end
  endtask

  task automatic check_result(input string tag);
    logic [W-1:0] q, r;
    logic z;
    q = exp_q.pop_front();
    r = exp_r.pop_front();
    z = exp_z.pop_front();
    check({tag, "_quotient"}, bus.quotient, q);
    check({tag, "_remainder"}, bus.remainder, r);
    check({tag, "_dbz"}, bus.div_by_zero, z);
  endtask

  task automatic full_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int bc;
    bit seen;
    push_model(a, b);
    launch(a, b);
    wait_done(bc, seen);
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_busy_cycles"}, bc, (b == 0) ? 0 : W);
    check_result(tag);
  endtask

  initial begin
    int bc;
    bit seen;
    int extra_done;
    logic [W-1:0] a, b;
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    tick();
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_quotient", bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_dbz", bus.div_by_zero, 0);
    rst_n = 1'b1;
    tick();

    // Directed cases
    full_div("d100_7", 8'd100, 8'd7);
    tick();
    check("done_one_cycle", bus.done, 0);
    full_div("d255_1", 8'd255, 8'd1);
    full_div("d5_9", 8'd5, 8'd9);
    full_div("d255_255", 8'd255, 8'd255);
    full_div("d200_0", 8'd200, 8'd0);
    tick();
    full_div("d0_3", 8'd0, 8'd3);

    // start pulse mid-run must be ignored
    push_model(8'd100, 8'd7);
    launch(8'd100, 8'd7);
    tick();
    tick();
    bus.dividend = 8'd50;
    bus.divisor  = 8'd5;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    wait_done(bc, seen);
    check("ign_done_seen", seen, 1);
    check_result("ign");
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) extra_done++;
    end
    check("ign_extra_done", extra_done, 0);

    // reset mid-run aborts
    launch(8'd100, 8'd7);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_quotient", bus.quotient, 0);
    check("abort_remainder", bus.remainder, 0);
    check("abort_dbz", bus.div_by_zero, 0);
    tick();
    check("abort_idle_busy", bus.busy, 0);
    full_div("d9_2", 8'd9, 8'd2);

    // start held through DONE: back-to-back with no idle cycle
    tick();
    push_model(8'd100, 8'd7);
    push_model(8'd60, 8'd4);
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    tick();
    bus.dividend = 8'd60;
    bus.divisor  = 8'd4;
    wait_done(bc, seen);
    check("b2b_first_seen", seen, 1);
    check_result("b2b_first");
    tick();
    bus.start = 1'b0;
    check("b2b_no_idle_busy", bus.busy, 1);
    wait_done(bc, seen);
    check("b2b_second_seen", seen, 1);
    check("b2b_second_busy_cycles", bc, W);
    check_result("b2b_second");

    // Randomized sweep, with zero and extreme divisors mixed in
    for (int n = 0; n < 3000; n++) begin
      a = W'($urandom_range(0, 255));
      case ($urandom_range(0, 15))
        0:       b = '0;
        1:       b = 8'd1;
        2:       b = 8'd255;
        default: b = W'($urandom_range(1, 255));
      endcase
      full_div("rand", a, b);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
